// File: rtl/axil_regbank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
// Response encodings and byte-lane helper used by the top and the write channel.
package axil_regbank_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for the register bank.
// The master drives requests; the slave drives ready and response signals.
interface axil_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_regbank_wr_ch.sv
// Write channel: captures AW and W independently, commits when both are present,
// owns the RW register storage and produces the per-register write strobes.
module axil_regbank_wr_ch
  import axil_regbank_pkg::*;
#(
  parameter int              DATA_W  = 32,
  parameter int              NUM_RW  = 4,
  parameter int              ADDR_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output resp_t                    bresp,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [NUM_RW*DATA_W-1:0] ctrl,
  output logic [NUM_RW-1:0]        wr_pulse
);
  localparam int LANES = lane_count(DATA_W);
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = ADDR_W - LSB;

  logic              aw_held_reg;
  logic              w_held_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] data_reg;
  logic [LANES-1:0]  strb_reg;

  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic              hit_rw;
  logic [IDX_W-1:0]  idx_cur;
  logic [DATA_W-1:0] data_cur;
  logic [LANES-1:0]  strb_cur;
  logic [DATA_W-1:0] lane_mask;

  // Ready is forced low while reset is held so the bus sees no acceptance.
  assign awready = rst_n && !aw_held_reg && !bvalid;
  assign wready  = rst_n && !w_held_reg && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign commit  = (aw_hs || aw_held_reg) && (w_hs || w_held_reg) && !bvalid;

  assign idx_cur  = aw_hs ? awaddr[ADDR_W-1:LSB] : idx_reg;
  assign data_cur = w_hs ? wdata : data_reg;
  assign strb_cur = w_hs ? wstrb : strb_reg;
  assign hit_rw   = int'(idx_cur) < NUM_RW;

  logic unused_lsb;
  assign unused_lsb = ^awaddr[LSB-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      idx_reg     <= '0;
      data_reg    <= '0;
      strb_reg    <= '0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
    end else if (commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      bvalid      <= 1'b1;
      bresp       <= hit_rw ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        idx_reg     <= awaddr[ADDR_W-1:LSB];
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        data_reg   <= wdata;
        strb_reg   <= wstrb;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_mask[gi*8 +: 8] = {8{strb_cur[gi]}};
    end

    for (gi = 0; gi < NUM_RW; gi++) begin : g_reg
      logic [DATA_W-1:0] val_reg;
      logic              pulse_reg;
      logic              sel;

      assign sel = commit && (int'(idx_cur) == gi);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          val_reg   <= RST_VAL;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= sel;
          if (sel) begin
            val_reg <= (val_reg & ~lane_mask) | (data_cur & lane_mask);
          end
        end
      end

      assign ctrl[gi*DATA_W +: DATA_W] = val_reg;
      assign wr_pulse[gi]              = pulse_reg;
    end
  endgenerate

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: RW control registers followed by RO status registers.
// The read path lives here; write capture and storage sit in axil_regbank_wr_ch.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                NUM_RW  = 4,
  parameter int                NUM_RO  = 2,
  parameter int                ADDR_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  axil_regbank_if.slave            s_axi,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  output logic [NUM_RW-1:0]        wr_pulse_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i
);
  localparam int LSB      = $clog2(lane_count(DATA_W));
  localparam int IDX_W    = ADDR_W - LSB;
  localparam int NUM_REGS = NUM_RW + NUM_RO;

  axil_regbank_wr_ch #(
    .DATA_W  (DATA_W),
    .NUM_RW  (NUM_RW),
    .ADDR_W  (ADDR_W),
    .RST_VAL (RST_VAL)
  ) u_wr_ch (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .awaddr   (s_axi.awaddr),
    .awvalid  (s_axi.awvalid),
    .awready  (s_axi.awready),
    .wdata    (s_axi.wdata),
    .wstrb    (s_axi.wstrb),
    .wvalid   (s_axi.wvalid),
    .wready   (s_axi.wready),
    .bresp    (s_axi.bresp),
    .bvalid   (s_axi.bvalid),
    .bready   (s_axi.bready),
    .ctrl     (ctrl_o),
    .wr_pulse (wr_pulse_o)
  );

  logic [DATA_W-1:0] rd_words [NUM_REGS];
  logic [IDX_W-1:0]  ar_idx;
  logic              ar_hs;
  logic              rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;
  resp_t             rresp_reg;
  logic [DATA_W-1:0] rdata_next;
  resp_t             rresp_next;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[LSB-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RW; gi++) begin : g_rw_word
      assign rd_words[gi] = ctrl_o[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < NUM_RO; gi++) begin : g_ro_word
      assign rd_words[NUM_RW+gi] = status_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign ar_idx         = s_axi.araddr[ADDR_W-1:LSB];
  assign s_axi.arready  = ARESETN && !rvalid_reg;
  assign ar_hs          = s_axi.arvalid && s_axi.arready;
  assign s_axi.rvalid   = rvalid_reg;
  assign s_axi.rdata    = rdata_reg;
  assign s_axi.rresp    = rresp_reg;

  // Reads sample current register contents, so a same-edge write is not yet visible.
  always_comb begin
    rdata_next = '0;
    rresp_next = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(ar_idx) == i) begin
        rdata_next = rd_words[i];
        rresp_next = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rdata_next;
      rresp_reg  <= rresp_next;
    end else if (rvalid_reg && s_axi.rready) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank (DATA_W=32, NUM_RW=4, NUM_RO=2) with hand-computed expectations.
module tb_axil_regbank;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] ctrl;
  logic [3:0]   wr_pulse;
  logic [63:0]  status;

  int n_checks = 0;
  int n_fails  = 0;
  int pulse_cnt [4];
  logic [31:0] exp_ctrl [4];

  axil_regbank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axil_regbank #(
    .DATA_W(32), .NUM_RW(4), .NUM_RO(2), .ADDR_W(8), .RST_VAL(32'h0)
  ) dut (
    .ACLK       (clk),
    .ARESETN    (rst_n),
    .s_axi      (bus.slave),
    .ctrl_o     (ctrl),
    .wr_pulse_o (wr_pulse),
    .status_i   (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (wr_pulse[k]) pulse_cnt[k]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag);
    for (int k = 0; k < 4; k++) check($sformatf("%s_reg%0d", tag, k), ctrl[k*32 +: 32], exp_ctrl[k]);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    int t;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.bready = 1'b0;
    for (t = 0; t < 64 && !(aw_done && w_done); t++) begin
      @(negedge clk);
      bus.awvalid = !aw_done && (t >= w_lead);
      bus.wvalid  = !w_done;
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
    end
    check("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    for (t = 0; t < 64 && !bus.bvalid; t++) @(negedge clk);
    check("bvalid_seen", bus.bvalid, 1);
    for (int i = 0; i < b_hold; i++) begin
      check("bvalid_hold", bus.bvalid, 1);
      check("awready_hold", bus.awready, 0);
      check("wready_hold", bus.wready, 0);
      @(negedge clk);
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    $display("WR addr=%02h data=%08h strb=%h resp=%0d", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0;
    int t;
    bus.araddr = addr;
    bus.rready = 1'b1;
    for (t = 0; t < 64 && !ar_done; t++) begin
      @(negedge clk);
      bus.arvalid = 1'b1;
      if (bus.arready) ar_done = 1;
    end
    check("rd_accept", ar_done, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (t = 0; t < 64 && !bus.rvalid; t++) @(negedge clk);
    check("rvalid_seen", bus.rvalid, 1);
    data = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    $display("RD addr=%02h data=%08h resp=%0d", addr, data, resp);
  endtask

  logic [1:0]  wr_resp;
  logic [1:0]  rd_resp;
  logic [31:0] rd_data;
  int          pulse_sum;

  initial begin
    bus.awaddr = '0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    status = {32'hCAFE0001, 32'h12345678};
    for (int k = 0; k < 4; k++) begin pulse_cnt[k] = 0; exp_ctrl[k] = 32'h0; end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check_ctrl("rst_ctrl");
    rst_n = 1'b1;
    #1;
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_wready", bus.wready, 1);
    check("post_rst_arready", bus.arready, 1);

    // Sequential writes and readback
    for (int k = 0; k < 4; k++) begin
      axi_write(8'(k * 4), 32'(k + 1), 4'hF, 0, 0, wr_resp);
      check($sformatf("seq_wr%0d_resp", k), wr_resp, 2'b00);
      exp_ctrl[k] = 32'(k + 1);
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(8'(k * 4), rd_data, rd_resp);
      check($sformatf("seq_rd%0d_data", k), rd_data, 32'(k + 1));
      check($sformatf("seq_rd%0d_resp", k), rd_resp, 2'b00);
    end
    for (int k = 0; k < 4; k++) check($sformatf("pulse_cnt%0d", k), pulse_cnt[k], 1);
    check_ctrl("seq_ctrl");

    // W leads AW by three cycles, partial strobe merge
    axi_write(8'h04, 32'hDEADBEEF, 4'b0101, 3, 0, wr_resp);
    check("strb_resp", wr_resp, 2'b00);
    exp_ctrl[1] = 32'h00AD00EF;
    axi_read(8'h04, rd_data, rd_resp);
    check("strb_data", rd_data, 32'h00AD00EF);

    // Status registers and write to RO
    axi_read(8'h10, rd_data, rd_resp);
    check("ro0_data", rd_data, 32'h12345678);
    check("ro0_resp", rd_resp, 2'b00);
    axi_read(8'h14, rd_data, rd_resp);
    check("ro1_data", rd_data, 32'hCAFE0001);
    check("ro1_resp", rd_resp, 2'b00);
    pulse_sum = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    axi_write(8'h10, 32'hFFFFFFFF, 4'hF, 0, 0, wr_resp);
    check("ro_wr_resp", wr_resp, 2'b10);
    check("ro_wr_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], pulse_sum);
    axi_read(8'h10, rd_data, rd_resp);
    check("ro0_after_wr", rd_data, 32'h12345678);

    // Unmapped read and write
    axi_read(8'h20, rd_data, rd_resp);
    check("unmap_rd_data", rd_data, 32'h0);
    check("unmap_rd_resp", rd_resp, 2'b10);
    axi_write(8'h3C, 32'h55AA55AA, 4'hF, 0, 0, wr_resp);
    check("unmap_wr_resp", wr_resp, 2'b10);
    check_ctrl("unmap_ctrl");

    // Back-pressure on B for ten cycles
    axi_write(8'h0C, 32'h00000044, 4'hF, 0, 10, wr_resp);
    check("bhold_resp", wr_resp, 2'b00);
    exp_ctrl[3] = 32'h00000044;
    check_ctrl("bhold_ctrl");

    // Same-edge read and write of register 2
    fork
      axi_write(8'h08, 32'h00000009, 4'hF, 0, 0, wr_resp);
      axi_read(8'h08, rd_data, rd_resp);
    join
    check("same_edge_rd", rd_data, 32'h3);
    check("same_edge_wr_resp", wr_resp, 2'b00);
    exp_ctrl[2] = 32'h9;
    axi_read(8'h08, rd_data, rd_resp);
    check("after_same_edge_rd", rd_data, 32'h9);

    // Reset while BVALID is high
    @(negedge clk);
    bus.awaddr = 8'h00; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("pre_rst_bvalid", bus.bvalid, 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) exp_ctrl[k] = 32'h0;
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_awready", bus.awready, 0);
    check_ctrl("mid_rst_ctrl");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_awready", bus.awready, 1);
    check("rel_wready", bus.wready, 1);
    check("rel_arready", bus.arready, 1);
    check("rel_bvalid", bus.bvalid, 0);
    $display("RST mid-transaction released");
    axi_read(8'h00, rd_data, rd_resp);
    check("rel_rd_reg0", rd_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
